// File: rtl/rc522_pkg.sv
// Shared types and constants for the RC522 register-access arbiter:
// FSM states, well-known RC522 register addresses and the address-byte encoder.
package rc522_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR_LOAD = 3'd1,
        ADDR_WAIT = 3'd2,
        GAP       = 3'd3,
        DATA_LOAD = 3'd4,
        DATA_WAIT = 3'd5,
        FINISH    = 3'd6
    } arb_state_e;

    localparam logic [5:0] TX_MODE_REG    = 6'h12;
    localparam logic [5:0] RX_MODE_REG    = 6'h13;
    localparam logic [5:0] TX_CONTROL_REG = 6'h14;
    localparam logic [5:0] TX_ASK_REG     = 6'h15;
    localparam logic [5:0] MOD_WIDTH_REG  = 6'h24;
    localparam logic [5:0] TMODE_REG      = 6'h2A;

    localparam logic [7:0] READ_DUMMY_BYTE = 8'h00;

    // RC522 SPI address byte: MSB selects read, LSB is always zero.
    function automatic logic [7:0] addr_byte(input logic rw, input logic [5:0] addr);
        return {rw, addr, 1'b0};
    endfunction

endpackage

// File: rtl/rc522_spi_arbiter_rr.sv
// Round-robin requester selection: the index at ptr has highest priority,
// priority decreasing with wrap-around distance from ptr.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt_oh,
    output logic [IW-1:0]   gnt_idx,
    output logic            any
);

    int best_s;
    int dist_s;

    // Pick the requesting index closest (cyclically) to the priority pointer.
    always_comb begin
        best_s  = NREQ;
        dist_s  = 0;
        gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (req[k]) begin
                dist_s = (k + NREQ - int'(ptr)) % NREQ;
                if (dist_s < best_s) begin
                    best_s  = dist_s;
                    gnt_idx = IW'(k);
                end else begin
                    best_s = best_s;
                end
            end else begin
                dist_s = dist_s;
            end
        end
        any = (best_s < NREQ);
        for (int k = 0; k < NREQ; k++) begin
            gnt_oh[k] = any && (gnt_idx == IW'(k));
        end
    end

endmodule

// File: rtl/rc522_spi_arbiter.sv
// Arbitrates several requesters onto one spi_master for two-byte RC522
// register reads/writes, with per-phase busy timeouts.
module rc522_spi_arbiter
    import rc522_pkg::*;
#(
    parameter int          NREQ        = 2,
    parameter logic [27:0] TIMEOUT_CYC = 28'd50000000,
    parameter int          GAP_CYC     = 8
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   req_rw,
    input  logic [6*NREQ-1:0] req_addr,
    input  logic [8*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [7:0]        rdata,
    output logic              timeout,
    output logic              spi_start,
    output logic [7:0]        spi_data_in,
    input  logic              spi_busy,
    input  logic [7:0]        spi_data_out
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e      state_q, state_d;
    logic            load_ph_q, load_ph_d;
    logic            seen_busy_q, seen_busy_d;
    logic [27:0]     cnt_q, cnt_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   own_q, own_d;
    logic            rw_q, rw_d;
    logic [5:0]      addr_q, addr_d;
    logic [7:0]      wdata_q, wdata_d;
    logic            to_q, to_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            timeout_q, timeout_d;
    logic            spi_start_q, spi_start_d;
    logic [7:0]      spi_data_in_q, spi_data_in_d;

    logic [NREQ-1:0] arb_oh_s;
    logic [IW-1:0]   arb_idx_s;
    logic            arb_any_s;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
        .req     (req),
        .ptr     (ptr_q),
        .gnt_oh  (arb_oh_s),
        .gnt_idx (arb_idx_s),
        .any     (arb_any_s)
    );

    // Next-state and registered-output logic for the transaction sequencer.
    always_comb begin
        state_d       = state_q;
        load_ph_d     = load_ph_q;
        seen_busy_d   = seen_busy_q;
        cnt_d         = cnt_q;
        ptr_d         = ptr_q;
        own_d         = own_q;
        rw_d          = rw_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        to_d          = to_q;
        gnt_d         = '0;
        done_d        = '0;
        rdata_d       = rdata_q;
        timeout_d     = 1'b0;
        spi_start_d   = 1'b1;
        spi_data_in_d = spi_data_in_q;

        case (state_q)
            IDLE: begin
                if (arb_any_s) begin
                    gnt_d     = arb_oh_s;
                    own_d     = arb_idx_s;
                    rw_d      = req_rw[arb_idx_s];
                    addr_d    = req_addr[arb_idx_s*6 +: 6];
                    wdata_d   = req_wdata[arb_idx_s*8 +: 8];
                    to_d      = 1'b0;
                    load_ph_d = 1'b0;
                    state_d   = ADDR_LOAD;
                    if (arb_idx_s == IW'(NREQ - 1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = arb_idx_s + IW'(1);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            // Each LOAD state takes two cycles: byte first, then the start strobe.
            ADDR_LOAD, DATA_LOAD: begin
                if (!load_ph_q) begin
                    spi_data_in_d = (state_q == ADDR_LOAD) ? addr_byte(rw_q, addr_q)
                                  : (rw_q ? READ_DUMMY_BYTE : wdata_q);
                    load_ph_d     = 1'b1;
                end else begin
                    spi_start_d = 1'b0;
                    load_ph_d   = 1'b0;
                    seen_busy_d = 1'b0;
                    cnt_d       = 28'd0;
                    state_d     = (state_q == ADDR_LOAD) ? ADDR_WAIT : DATA_WAIT;
                end
            end
            ADDR_WAIT, DATA_WAIT: begin
                if (seen_busy_q && !spi_busy) begin
                    cnt_d = 28'd0;
                    if (state_q == ADDR_WAIT) begin
                        state_d = GAP;
                    end else begin
                        rdata_d = rw_q ? spi_data_out : rdata_q;
                        state_d = FINISH;
                    end
                end else if (cnt_q >= TIMEOUT_CYC - 28'd1) begin
                    to_d    = 1'b1;
                    state_d = FINISH;
                end else begin
                    cnt_d       = cnt_q + 28'd1;
                    seen_busy_d = seen_busy_q | spi_busy;
                end
            end
            GAP: begin
                if (cnt_q >= 28'(GAP_CYC - 1)) begin
                    cnt_d     = 28'd0;
                    load_ph_d = 1'b0;
                    state_d   = DATA_LOAD;
                end else begin
                    cnt_d = cnt_q + 28'd1;
                end
            end
            FINISH: begin
                done_d[own_q] = 1'b1;
                timeout_d     = to_q;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            load_ph_q     <= 1'b0;
            seen_busy_q   <= 1'b0;
            cnt_q         <= 28'd0;
            ptr_q         <= '0;
            own_q         <= '0;
            rw_q          <= 1'b0;
            addr_q        <= 6'h00;
            wdata_q       <= 8'h00;
            to_q          <= 1'b0;
            gnt_q         <= '0;
            done_q        <= '0;
            rdata_q       <= 8'h00;
            timeout_q     <= 1'b0;
            spi_start_q   <= 1'b1;
            spi_data_in_q <= 8'h00;
        end else begin
            state_q       <= state_d;
            load_ph_q     <= load_ph_d;
            seen_busy_q   <= seen_busy_d;
            cnt_q         <= cnt_d;
            ptr_q         <= ptr_d;
            own_q         <= own_d;
            rw_q          <= rw_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            to_q          <= to_d;
            gnt_q         <= gnt_d;
            done_q        <= done_d;
            rdata_q       <= rdata_d;
            timeout_q     <= timeout_d;
            spi_start_q   <= spi_start_d;
            spi_data_in_q <= spi_data_in_d;
        end
    end

    assign gnt         = gnt_q;
    assign done        = done_q;
    assign rdata       = rdata_q;
    assign timeout     = timeout_q;
    assign spi_start   = spi_start_q;
    assign spi_data_in = spi_data_in_q;

endmodule
